// File: rtl/iob2axi_burst_gen_pkg.sv
// Shared types and constants for the IOb-to-AXI burst generator.
// Holds the AXI page geometry, response codes and the controller state encoding.
package iob2axi_burst_gen_pkg;

  // AXI bursts may not cross a 2^AXI_4K_W byte page.
  localparam int unsigned AXI_4K_W = 12;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iob2axi_burst_calc.sv
// Combinational sizing of the next burst: beats limited by the remaining count, the
// maximum burst length and the distance to the next 4 KiB page.
module iob2axi_burst_calc
  import iob2axi_burst_gen_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W    = 32,
  parameter int unsigned AXI_DATA_W    = 32,
  parameter int unsigned AXI_LEN_W     = 8,
  parameter int unsigned MAX_BURST_LEN = 256,
  parameter int unsigned XFER_LEN_W    = 16
) (
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [XFER_LEN_W-1:0] remaining_i,
  output logic [XFER_LEN_W-1:0] beats_o,
  output logic [AXI_LEN_W-1:0]  len_o,
  output logic                  last_o,
  output logic [AXI_ADDR_W-1:0] next_addr_o
);

  localparam int unsigned ByteShift = $clog2(AXI_DATA_W / 8);
  // Wide enough for both the remaining count and a full page of bytes.
  localparam int unsigned CalcW     = umax(XFER_LEN_W, AXI_4K_W + 1);
  localparam logic [CalcW-1:0] PageBytes = CalcW'(1 << AXI_4K_W);
  localparam logic [CalcW-1:0] MaxBeats  = CalcW'(MAX_BURST_LEN);

  logic [CalcW-1:0] offset;
  logic [CalcW-1:0] room;
  logic [CalcW-1:0] rem;
  logic [CalcW-1:0] capped;
  logic [CalcW-1:0] beats;

  always_comb begin
    offset      = CalcW'(addr_i[AXI_4K_W-1:0]);
    room        = (PageBytes - offset) >> ByteShift;
    rem         = CalcW'(remaining_i);
    capped      = (rem < MaxBeats) ? rem : MaxBeats;
    beats       = (room < capped) ? room : capped;
    beats_o     = beats[XFER_LEN_W-1:0];
    len_o       = AXI_LEN_W'(beats - CalcW'(1));
    last_o      = (beats == rem);
    next_addr_o = addr_i + (AXI_ADDR_W'(beats) << ByteShift);
  end

endmodule

// File: rtl/iob2axi_burst_gen.sv
// Splits one transfer request into AXI address-channel bursts that respect the 4 KiB
// boundary and the burst-length limit, with a bounded number of outstanding bursts.
module iob2axi_burst_gen
  import iob2axi_burst_gen_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_DATA_W      = 32,
  parameter int unsigned AXI_LEN_W       = 8,
  parameter int unsigned MAX_BURST_LEN   = 256,
  parameter int unsigned XFER_LEN_W      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic                  direction_i,
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [XFER_LEN_W-1:0] length_i,
  output logic                  ready_o,
  output logic                  error_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic                  cmd_dir_o,
  output logic [AXI_ADDR_W-1:0] cmd_addr_o,
  output logic [AXI_LEN_W-1:0]  cmd_len_o,
  output logic                  cmd_last_o,
  input  logic                  done_valid_i,
  input  logic                  done_err_i
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0]       MaxOut    = OutW'(MAX_OUTSTANDING);
  localparam logic [AXI_ADDR_W-1:0] AlignMask = AXI_ADDR_W'(AXI_DATA_W / 8 - 1);

  state_e                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [XFER_LEN_W-1:0] rem_q, rem_d;
  logic                  dir_q, dir_d;
  logic [OutW-1:0]       out_q, out_d;
  logic                  error_q, error_d;

  logic [XFER_LEN_W-1:0] beats;
  logic [AXI_LEN_W-1:0]  burst_len;
  logic                  burst_last;
  logic [AXI_ADDR_W-1:0] next_addr;
  logic                  cmd_valid;
  logic                  cmd_hs;
  logic                  done_ok;

  iob2axi_burst_calc #(
    .AXI_ADDR_W   (AXI_ADDR_W),
    .AXI_DATA_W   (AXI_DATA_W),
    .AXI_LEN_W    (AXI_LEN_W),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .XFER_LEN_W   (XFER_LEN_W)
  ) u_calc (
    .addr_i     (addr_q),
    .remaining_i(rem_q),
    .beats_o    (beats),
    .len_o      (burst_len),
    .last_o     (burst_last),
    .next_addr_o(next_addr)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    out_d   = out_q;
    error_d = error_q;

    cmd_valid = (state_q == StIssue) && (out_q < MaxOut) && !error_q;
    cmd_hs    = cmd_valid && cmd_ready_i;
    done_ok   = done_valid_i && (out_q != '0);

    if (cmd_hs && !done_ok) begin
      out_d = out_q + OutW'(1);
    end else if (!cmd_hs && done_ok) begin
      out_d = out_q - OutW'(1);
    end
    // A completion with nothing outstanding is a protocol violation.
    if (done_valid_i && (done_err_i || (out_q == '0))) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          if ((length_i == '0) || ((addr_i & AlignMask) != '0)) begin
            error_d = 1'b1;
          end else begin
            error_d = 1'b0;
            addr_d  = addr_i;
            rem_d   = length_i;
            dir_d   = direction_i;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (cmd_hs) begin
          addr_d = next_addr;
          rem_d  = rem_q - beats;
          if (burst_last) begin
            state_d = StDrain;
          end
        end
        if (error_d) begin
          state_d = (out_d == '0) ? StIdle : StDrain;
        end
      end
      StDrain: begin
        if (out_d == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      error_q <= error_d;
    end
  end

  // Length/last are only meaningful while issuing; zero otherwise.
  assign ready_o     = (state_q == StIdle);
  assign error_o     = error_q;
  assign cmd_valid_o = cmd_valid;
  assign cmd_dir_o   = dir_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_len_o   = (state_q == StIssue) ? burst_len : '0;
  assign cmd_last_o  = (state_q == StIssue) ? burst_last : 1'b0;

endmodule

// File: tb/tb_iob2axi_burst_gen.sv
// Directed bench for iob2axi_burst_gen: a table of requests with their expected burst
// commands, plus hand sequences for credit limiting, error draining and reset.
module tb_iob2axi_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i, direction_i;
  logic [31:0] addr_i;
  logic [15:0] length_i;
  logic        ready_o, error_o, cmd_valid_o, cmd_ready_i, cmd_dir_o, cmd_last_o;
  logic [31:0] cmd_addr_o;
  logic [7:0]  cmd_len_o;
  logic        done_valid_i, done_err_i;

  always #5 clk = ~clk;

  iob2axi_burst_gen #(
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run_i),
    .direction_i (direction_i),
    .addr_i      (addr_i),
    .length_i    (length_i),
    .ready_o     (ready_o),
    .error_o     (error_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_dir_o   (cmd_dir_o),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_len_o   (cmd_len_o),
    .cmd_last_o  (cmd_last_o),
    .done_valid_i(done_valid_i),
    .done_err_i  (done_err_i)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      len;
    logic             dir;
    logic             err;
    logic [1:0]       ncmd;
    logic [2:0][31:0] ea;
    logic [2:0][7:0]  el;
    logic [2:0]       elast;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] l, input logic d);
    @(negedge clk);
    run_i = 1'b1; addr_i = a; length_i = l; direction_i = d;
    @(negedge clk);
    run_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_error"}, 32'(error_o), 32'd0);
    chk({tag, "_valid"}, 32'(cmd_valid_o), 32'd0);
    chk({tag, "_addr"}, cmd_addr_o, 32'd0);
    chk({tag, "_len"}, 32'(cmd_len_o), 32'd0);
    chk({tag, "_last"}, 32'(cmd_last_o), 32'd0);
    chk({tag, "_dir"}, 32'(cmd_dir_o), 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] l, input logic d,
                              input logic e, input logic [1:0] n,
                              input logic [31:0] a0, input logic [7:0] l0, input logic z0,
                              input logic [31:0] a1, input logic [7:0] l1, input logic z1,
                              input logic [31:0] a2, input logic [7:0] l2, input logic z2);
    vec_t v;
    v.addr = a; v.len = l; v.dir = d; v.err = e; v.ncmd = n;
    v.ea[0] = a0; v.el[0] = l0; v.elast[0] = z0;
    v.ea[1] = a1; v.el[1] = l1; v.elast[1] = z1;
    v.ea[2] = a2; v.el[2] = l2; v.elast[2] = z2;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int hs;
    int tb_out;
    int waited;
    logic d;

    vecs[0] = mk(32'h0, 16'd16, 1'b0, 1'b0, 2'd1, 32'h0, 8'd15, 1'b1, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(32'h0FF0, 16'd8, 1'b1, 1'b0, 2'd2, 32'h0FF0, 8'd3, 1'b0,
                 32'h1000, 8'd3, 1'b1, 0, 0, 0);
    vecs[2] = mk(32'h0, 16'd600, 1'b0, 1'b0, 2'd3, 32'h000, 8'd255, 1'b0,
                 32'h400, 8'd255, 1'b0, 32'h800, 8'd87, 1'b1);
    vecs[3] = mk(32'h2, 16'd4, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(32'h100, 16'd0, 1'b1, 1'b1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(32'h0FFC, 16'd1, 1'b1, 1'b0, 2'd1, 32'h0FFC, 8'd0, 1'b1, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(32'hFFFF_FFF8, 16'd4, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFF8, 8'd1, 1'b0,
                 32'h0, 8'd1, 1'b1, 0, 0, 0);

    rst = 1'b1; run_i = 1'b0; direction_i = 1'b0; addr_i = '0; length_i = '0;
    cmd_ready_i = 1'b0; done_valid_i = 1'b0; done_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_rel");

    for (int v = 0; v < 7; v++) begin
      start(vecs[v].addr, vecs[v].len, vecs[v].dir);
      if (vecs[v].err) begin
        chk($sformatf("v%0d_err", v), 32'(error_o), 32'd1);
        chk($sformatf("v%0d_ready", v), 32'(ready_o), 32'd1);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_novalid", v), 32'(cmd_valid_o), 32'd0);
      end else begin
        chk($sformatf("v%0d_first_valid", v), 32'(cmd_valid_o), 32'd1);
        chk($sformatf("v%0d_err_clr", v), 32'(error_o), 32'd0);
        for (int k = 0; k < int'(vecs[v].ncmd); k++) begin
          waited = 0;
          while (!cmd_valid_o && waited < 20) begin
            @(negedge clk);
            waited++;
          end
          chk($sformatf("v%0d_c%0d_valid", v, k), 32'(cmd_valid_o), 32'd1);
          chk($sformatf("v%0d_c%0d_addr", v, k), cmd_addr_o, vecs[v].ea[k]);
          chk($sformatf("v%0d_c%0d_len", v, k), 32'(cmd_len_o), 32'(vecs[v].el[k]));
          chk($sformatf("v%0d_c%0d_last", v, k), 32'(cmd_last_o), 32'(vecs[v].elast[k]));
          chk($sformatf("v%0d_c%0d_dir", v, k), 32'(cmd_dir_o), 32'(vecs[v].dir));
          cmd_ready_i = 1'b1;
          @(negedge clk);
          cmd_ready_i = 1'b0; done_valid_i = 1'b1;
          @(negedge clk);
          done_valid_i = 1'b0;
        end
        chk($sformatf("v%0d_ready_end", v), 32'(ready_o), 32'd1);
        chk($sformatf("v%0d_err_end", v), 32'(error_o), 32'd0);
      end
    end

    // Credit limit: two handshakes, then stall until a completion frees a slot.
    start(32'h0, 16'd1024, 1'b0);
    cmd_ready_i = 1'b1;
    hs = 0;
    repeat (6) begin
      if (cmd_valid_o) hs++;
      @(negedge clk);
    end
    cmd_ready_i = 1'b0;
    chk("credit_hs", 32'(hs), 32'd2);
    chk("credit_stall", 32'(cmd_valid_o), 32'd0);
    done_valid_i = 1'b1;
    @(negedge clk);
    done_valid_i = 1'b0;
    chk("credit_resume", 32'(cmd_valid_o), 32'd1);
    chk("credit_addr", cmd_addr_o, 32'h800);
    chk("credit_len", 32'(cmd_len_o), 32'd255);
    tb_out = 1;
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 40 && !ready_o; i++) begin
      d = (tb_out > 0);
      done_valid_i = d;
      if (cmd_valid_o) begin
        hs++;
        tb_out++;
      end
      if (d) tb_out--;
      @(negedge clk);
    end
    cmd_ready_i = 1'b0; done_valid_i = 1'b0;
    chk("credit_total_hs", 32'(hs), 32'd4);
    chk("credit_ready", 32'(ready_o), 32'd1);
    chk("credit_err", 32'(error_o), 32'd0);

    // Error completion on the first of three bursts stops issue and drains.
    start(32'h0, 16'd600, 1'b1);
    cmd_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    cmd_ready_i = 1'b0;
    done_valid_i = 1'b1; done_err_i = 1'b1;
    @(negedge clk);
    done_valid_i = 1'b0; done_err_i = 1'b0;
    chk("derr_error", 32'(error_o), 32'd1);
    chk("derr_novalid", 32'(cmd_valid_o), 32'd0);
    chk("derr_busy", 32'(ready_o), 32'd0);
    done_valid_i = 1'b1;
    @(negedge clk);
    done_valid_i = 1'b0;
    chk("derr_ready", 32'(ready_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("derr_sticky", 32'(error_o), 32'd1);
    chk("derr_novalid2", 32'(cmd_valid_o), 32'd0);

    // Reset in the middle of issuing.
    start(32'h40, 16'd600, 1'b1);
    chk("mid_err_clr", 32'(error_o), 32'd0);
    chk("mid_valid", 32'(cmd_valid_o), 32'd1);
    chk("mid_addr", cmd_addr_o, 32'h40);
    chk("mid_dir", 32'(cmd_dir_o), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst_async");
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("mid_rst");

    // Completion with nothing outstanding flags an error.
    @(negedge clk);
    done_valid_i = 1'b1;
    @(negedge clk);
    done_valid_i = 1'b0;
    chk("stray_done_err", 32'(error_o), 32'd1);
    chk("stray_done_ready", 32'(ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
